// File: rtl/alu_exec_unit_pkg.sv
// Shared RV32I execute-stage types: ALU opcodes, operand selects, issue and CDB records.
package alu_exec_unit_pkg;

  localparam int unsigned PREG_W    = 6;
  localparam int unsigned ROB_IDX_W = 5;

  typedef enum logic [3:0] {
    AluAdd, AluSub, AluSll, AluSrl, AluSra, AluSlt, AluSltu, AluXor, AluOr, AluAnd
  } alu_op_t;

  typedef enum logic [1:0] {Op1Rs1, Op1Pc, Op1Zero} op1_sel_t;

  typedef enum logic {Op2Rs2, Op2Imm} op2_sel_t;

  typedef struct packed {
    logic                 valid;
    logic [PREG_W-1:0]    pd;
    logic [ROB_IDX_W-1:0] rob_id;
    logic [PREG_W-1:0]    ps1;
    logic [PREG_W-1:0]    ps2;
    alu_op_t              alu_op;
    op1_sel_t             op1_sel;
    op2_sel_t             op2_sel;
    logic [31:0]          imm;
    logic [31:0]          pc;
  } rs_to_alu_t;

  typedef struct packed {
    logic                 valid;
    logic [PREG_W-1:0]    pd;
    logic [ROB_IDX_W-1:0] rob_id;
    logic [31:0]          data;
  } cdb_entry_t;

endpackage

// File: rtl/alu_result_fifo.sv
// In-order result buffer between the ALU and the CDB arbiter; flush empties it in one edge.
module alu_result_fifo
  import alu_exec_unit_pkg::*;
#(
  parameter int unsigned DEPTH = 3,
  localparam int unsigned CNT_W = $clog2(DEPTH + 1),
  localparam int unsigned PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             push,
  input  cdb_entry_t       push_data,
  input  logic             pop,
  output cdb_entry_t       head,
  output logic [CNT_W-1:0] count,
  output logic             empty
);

  cdb_entry_t       mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (pop) rd_ptr <= ptr_inc(rd_ptr);
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: entries are only visible through count.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_data;
  end

  assign head  = mem[rd_ptr];
  assign empty = (count == '0);

  assert property (@(posedge clk) disable iff (rst || flush) !(push && count == CNT_W'(DEPTH)));

endmodule

// File: rtl/alu_exec_unit.sv
// RV32I integer execute stage: one E register, inline ALU, credit-managed result buffer to CDB.
module alu_exec_unit
  import alu_exec_unit_pkg::*;
#(
  parameter int unsigned RESULT_DEPTH = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  rs_to_alu_t        iss,
  output logic              alu_is_ready,
  output logic [PREG_W-1:0] prf_rs1_addr,
  output logic [PREG_W-1:0] prf_rs2_addr,
  input  logic [31:0]       prf_rs1_data,
  input  logic [31:0]       prf_rs2_data,
  output logic              cdb_req,
  output cdb_entry_t        cdb_out,
  input  logic              cdb_grant
);

  localparam int unsigned CNT_W = $clog2(RESULT_DEPTH + 1);

  logic                 accept;
  logic                 e_valid;
  logic [PREG_W-1:0]    e_pd;
  logic [ROB_IDX_W-1:0] e_rob_id;
  alu_op_t              e_alu_op;
  op1_sel_t             e_op1_sel;
  op2_sel_t             e_op2_sel;
  logic [31:0]          e_imm;
  logic [31:0]          e_pc;
  logic [31:0]          e_rs1;
  logic [31:0]          e_rs2;

  logic [31:0]          op1;
  logic [31:0]          op2;
  logic [4:0]           shamt;
  logic [31:0]          result;
  cdb_entry_t           push_data;
  cdb_entry_t           head;
  logic [CNT_W-1:0]     count;
  logic                 empty;
  logic [CNT_W:0]       in_flight;

  assign prf_rs1_addr = iss.ps1;
  assign prf_rs2_addr = iss.ps2;
  assign accept       = iss.valid & alu_is_ready & ~flush;

  always_ff @(posedge clk) begin
    if (rst || flush) e_valid <= 1'b0;
    else              e_valid <= accept;
    if (accept) begin
      e_pd      <= iss.pd;
      e_rob_id  <= iss.rob_id;
      e_alu_op  <= iss.alu_op;
      e_op1_sel <= iss.op1_sel;
      e_op2_sel <= iss.op2_sel;
      e_imm     <= iss.imm;
      e_pc      <= iss.pc;
      e_rs1     <= prf_rs1_data;
      e_rs2     <= prf_rs2_data;
    end
  end

  always_comb begin
    case (e_op1_sel)
      Op1Rs1:  op1 = e_rs1;
      Op1Pc:   op1 = e_pc;
      default: op1 = '0;
    endcase
    op2   = (e_op2_sel == Op2Imm) ? e_imm : e_rs2;
    shamt = op2[4:0];
    case (e_alu_op)
      AluAdd:  result = op1 + op2;
      AluSub:  result = op1 - op2;
      AluSll:  result = op1 << shamt;
      AluSrl:  result = op1 >> shamt;
      AluSra:  result = $unsigned($signed(op1) >>> shamt);
      AluSlt:  result = {31'b0, $signed(op1) < $signed(op2)};
      AluSltu: result = {31'b0, op1 < op2};
      AluXor:  result = op1 ^ op2;
      AluOr:   result = op1 | op2;
      AluAnd:  result = op1 & op2;
      default: result = '0;
    endcase
  end

  always_comb begin
    push_data        = '0;
    push_data.valid  = 1'b1;
    push_data.pd     = e_pd;
    push_data.rob_id = e_rob_id;
    push_data.data   = result;
  end

  alu_result_fifo #(
    .DEPTH (RESULT_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .push      (e_valid),
    .push_data (push_data),
    .pop       (cdb_req & cdb_grant),
    .head      (head),
    .count     (count),
    .empty     (empty)
  );

  assign cdb_req = ~empty & ~flush;

  // Zero the bus when idle so stale buffer contents never show on the CDB.
  always_comb begin
    cdb_out = '0;
    if (cdb_req) begin
      cdb_out       = head;
      cdb_out.valid = 1'b1;
    end
  end

  // Credits cover the E register plus the buffer; independent of cdb_grant.
  assign in_flight    = {{CNT_W{1'b0}}, e_valid} + {1'b0, count};
  assign alu_is_ready = in_flight < (CNT_W + 1)'(RESULT_DEPTH);

  assert property (@(posedge clk) disable iff (rst || flush) !(iss.valid && !alu_is_ready));

endmodule

// File: tb/tb_alu_exec_unit.sv
// Directed bench for alu_exec_unit: opcode vector table plus back-pressure, flush and reset sequences.
module tb_alu_exec_unit;
  import alu_exec_unit_pkg::*;

  logic              clk = 1'b0;
  logic              rst;
  logic              flush;
  rs_to_alu_t        iss;
  logic              alu_is_ready;
  logic [PREG_W-1:0] prf_rs1_addr;
  logic [PREG_W-1:0] prf_rs2_addr;
  logic [31:0]       prf_rs1_data;
  logic [31:0]       prf_rs2_data;
  logic              cdb_req;
  cdb_entry_t        cdb_out;
  logic              cdb_grant;

  logic [31:0] prf [1 << PREG_W];

  int errors = 0;
  int checks = 0;

  alu_exec_unit #(
    .RESULT_DEPTH (3)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .flush        (flush),
    .iss          (iss),
    .alu_is_ready (alu_is_ready),
    .prf_rs1_addr (prf_rs1_addr),
    .prf_rs2_addr (prf_rs2_addr),
    .prf_rs1_data (prf_rs1_data),
    .prf_rs2_data (prf_rs2_data),
    .cdb_req      (cdb_req),
    .cdb_out      (cdb_out),
    .cdb_grant    (cdb_grant)
  );

  always #5 clk = ~clk;

  assign prf_rs1_data = prf[prf_rs1_addr];
  assign prf_rs2_data = prf[prf_rs2_addr];

  typedef struct {
    alu_op_t              op;
    op1_sel_t             s1;
    op2_sel_t             s2;
    logic [31:0]          a;
    logic [31:0]          b;
    logic [31:0]          imm;
    logic [31:0]          pc;
    logic [PREG_W-1:0]    pd;
    logic [ROB_IDX_W-1:0] rob;
    logic [31:0]          exp;
  } vec_t;

  vec_t vecs [13];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic vec_t mkv(input alu_op_t op, input op1_sel_t s1, input op2_sel_t s2,
                               input logic [31:0] a, input logic [31:0] b,
                               input logic [31:0] imm, input logic [31:0] pc,
                               input int pd, input int rob, input logic [31:0] exp);
    vec_t v;
    v.op = op; v.s1 = s1; v.s2 = s2; v.a = a; v.b = b; v.imm = imm; v.pc = pc;
    v.pd = PREG_W'(pd); v.rob = ROB_IDX_W'(rob); v.exp = exp;
    return v;
  endfunction

  task automatic drive(input alu_op_t op, input op1_sel_t s1, input op2_sel_t s2,
                       input int ps1, input int ps2, input logic [31:0] imm,
                       input logic [31:0] pc, input int pd, input int rob);
    iss.valid   = 1'b1;
    iss.alu_op  = op;
    iss.op1_sel = s1;
    iss.op2_sel = s2;
    iss.ps1     = PREG_W'(ps1);
    iss.ps2     = PREG_W'(ps2);
    iss.imm     = imm;
    iss.pc      = pc;
    iss.pd      = PREG_W'(pd);
    iss.rob_id  = ROB_IDX_W'(rob);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int          accepted;
    int          got;
    int          seen;
    int          dropped;
    int          first;
    int          last;
    logic [31:0] expq [$];
    logic [31:0] e;

    for (int i = 0; i < (1 << PREG_W); i++) prf[i] = '0;
    vecs[0]  = mkv(AluAdd,  Op1Rs1,  Op2Rs2, 32'd5,        32'd7,        0, 0, 12, 3, 32'd12);
    vecs[1]  = mkv(AluSra,  Op1Rs1,  Op2Imm, 32'h8000_0000, 0, 32'h24, 0, 5, 4, 32'hF800_0000);
    vecs[2]  = mkv(AluSltu, Op1Rs1,  Op2Rs2, 32'd1, 32'hFFFF_FFFF, 0, 0, 6, 5, 32'd1);
    vecs[3]  = mkv(AluSlt,  Op1Rs1,  Op2Rs2, 32'd1, 32'hFFFF_FFFF, 0, 0, 7, 6, 32'd0);
    vecs[4]  = mkv(AluAdd,  Op1Pc,   Op2Imm, 32'hDEAD, 0, 32'h2000, 32'h1000, 8, 7, 32'h3000);
    vecs[5]  = mkv(AluAdd,  Op1Zero, Op2Imm, 32'hDEAD, 0, 32'h1234_5000, 32'h40, 9, 8,
                   32'h1234_5000);
    vecs[6]  = mkv(AluSub,  Op1Rs1,  Op2Rs2, 32'd3, 32'd5, 0, 0, 10, 9, 32'hFFFF_FFFE);
    vecs[7]  = mkv(AluSll,  Op1Rs1,  Op2Rs2, 32'd1, 32'h21, 0, 0, 11, 10, 32'd2);
    vecs[8]  = mkv(AluSrl,  Op1Rs1,  Op2Rs2, 32'h8000_0000, 32'd4, 0, 0, 13, 11, 32'h0800_0000);
    vecs[9]  = mkv(AluXor,  Op1Rs1,  Op2Rs2, 32'hF0F0_F0F0, 32'hFF00_FF00, 0, 0, 14, 12,
                   32'h0FF0_0FF0);
    vecs[10] = mkv(AluOr,   Op1Rs1,  Op2Rs2, 32'hF0F0_F0F0, 32'hFF00_FF00, 0, 0, 15, 13,
                   32'hFFF0_FFF0);
    vecs[11] = mkv(AluAnd,  Op1Rs1,  Op2Rs2, 32'hF0F0_F0F0, 32'hFF00_FF00, 0, 0, 16, 14,
                   32'hF000_F000);
    vecs[12] = mkv(AluSlt,  Op1Rs1,  Op2Rs2, 32'hFFFF_FFFF, 32'd1, 0, 0, 0, 15, 32'd1);

    rst       = 1'b1;
    flush     = 1'b0;
    cdb_grant = 1'b0;
    iss       = '0;
    repeat (2) @(negedge clk);
    chk("reset ready", alu_is_ready, 1);
    chk("reset cdb_req", cdb_req, 0);
    chk("reset cdb_out", cdb_out, 0);
    rst = 1'b0;
    @(negedge clk);

    // Opcode table, grant tied high: result appears exactly 2 cycles after issue for one cycle.
    cdb_grant = 1'b1;
    for (int i = 0; i < 13; i++) begin
      prf[1] = vecs[i].a;
      prf[2] = vecs[i].b;
      drive(vecs[i].op, vecs[i].s1, vecs[i].s2, 1, 2, vecs[i].imm, vecs[i].pc,
            int'(vecs[i].pd), int'(vecs[i].rob));
      @(negedge clk);
      iss.valid = 1'b0;
      chk($sformatf("vec%0d req@+1", i), cdb_req, 0);
      @(negedge clk);
      chk($sformatf("vec%0d req@+2", i), cdb_req, 1);
      chk($sformatf("vec%0d data", i), cdb_out.data, vecs[i].exp);
      chk($sformatf("vec%0d pd", i), cdb_out.pd, vecs[i].pd);
      chk($sformatf("vec%0d rob", i), cdb_out.rob_id, vecs[i].rob);
      chk($sformatf("vec%0d valid", i), cdb_out.valid, 1);
      @(negedge clk);
      chk($sformatf("vec%0d req@+3", i), cdb_req, 0);
    end

    // Grant held low: credits admit exactly three ops, then drain in order.
    cdb_grant = 1'b0;
    accepted  = 0;
    for (int c = 0; c < 8; c++) begin
      if (alu_is_ready) begin
        prf[10 + accepted] = 32'(accepted * 7);
        drive(AluAdd, Op1Rs1, Op2Imm, 10 + accepted, 0, 32'd100, 0, 20 + accepted, accepted);
        expq.push_back(32'(accepted * 7 + 100));
        accepted++;
      end else begin
        iss.valid = 1'b0;
      end
      @(negedge clk);
    end
    iss.valid = 1'b0;
    chk("stall accepted", 64'(accepted), 3);
    chk("stall ready", alu_is_ready, 0);
    chk("stall req", cdb_req, 1);
    chk("stall hold data", cdb_out.data, 32'd100);
    cdb_grant = 1'b1;
    got = 0;
    for (int c = 0; c < 10; c++) begin
      if (cdb_req) begin
        e = (expq.size() > 0) ? expq.pop_front() : 32'hBAD0_BAD0;
        chk($sformatf("drain data%0d", got), cdb_out.data, e);
        chk($sformatf("drain rob%0d", got), cdb_out.rob_id, ROB_IDX_W'(got));
        got++;
      end
      @(negedge clk);
    end
    chk("drain count", 64'(got), 3);
    chk("drain ready", alu_is_ready, 1);

    // Back-to-back with continuous grant: one result per cycle, no credit stall.
    expq.delete();
    got = 0; dropped = 0; first = -1; last = -1;
    for (int c = 0; c < 14; c++) begin
      if (cdb_req) begin
        e = (expq.size() > 0) ? expq.pop_front() : 32'hBAD0_BAD0;
        chk($sformatf("b2b data%0d", got), cdb_out.data, e);
        if (first < 0) first = c;
        last = c;
        got++;
      end
      if (c < 8) begin
        if (!alu_is_ready) dropped++;
        prf[30 + c] = 32'(c * 3 + 1);
        drive(AluAdd, Op1Rs1, Op2Imm, 30 + c, 0, 32'(c << 8), 0, c + 1, c);
        expq.push_back(32'(c * 3 + 1 + (c << 8)));
      end else begin
        iss.valid = 1'b0;
      end
      @(negedge clk);
    end
    chk("b2b ready drops", 64'(dropped), 0);
    chk("b2b count", 64'(got), 8);
    chk("b2b first cycle", 64'(first), 2);
    chk("b2b last cycle", 64'(last), 9);

    // Flush with E valid, two buffered, a same-cycle issue and grant: nothing survives.
    cdb_grant = 1'b0;
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("flush pre ready%0d", k), alu_is_ready, 1);
      prf[40 + k] = 32'(k + 50);
      drive(AluAdd, Op1Rs1, Op2Imm, 40 + k, 0, 0, 0, 1, k);
      @(negedge clk);
    end
    iss.valid = 1'b0;
    chk("flush pre ready", alu_is_ready, 0);
    chk("flush pre req", cdb_req, 1);
    flush = 1'b1;
    cdb_grant = 1'b1;
    drive(AluAdd, Op1Rs1, Op2Imm, 40, 0, 0, 0, 2, 9);
    @(negedge clk);
    flush = 1'b0;
    iss.valid = 1'b0;
    chk("flush req", cdb_req, 0);
    chk("flush ready", alu_is_ready, 1);
    chk("flush cdb_out", cdb_out, 0);
    seen = 0;
    for (int c = 0; c < 6; c++) begin
      if (cdb_req) seen++;
      @(negedge clk);
    end
    chk("flush no result", 64'(seen), 0);

    // Reset mid-stream while a result is requesting.
    cdb_grant = 1'b0;
    prf[3] = 32'd9;
    drive(AluAdd, Op1Rs1, Op2Imm, 3, 0, 32'd1, 0, 4, 1);
    @(negedge clk);
    iss.valid = 1'b0;
    for (int c = 0; c < 5 && !cdb_req; c++) @(negedge clk);
    chk("rst pre req", cdb_req, 1);
    chk("rst pre data", cdb_out.data, 32'd10);
    rst = 1'b1;
    @(negedge clk);
    chk("rst req", cdb_req, 0);
    chk("rst cdb_out", cdb_out, 0);
    chk("rst ready", alu_is_ready, 1);
    rst = 1'b0;
    @(negedge clk);
    chk("rst post req", cdb_req, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/alu_exec_unit.md
# alu_exec_unit

Integer execute stage directly downstream of the ALU reservation station. Accepts one issued ALU micro-op per cycle, reads its two source operands from the physical register file, computes the RV32I integer result, and queues it in a small result buffer. Results leave in order over a request/grant handshake to the CDB arbiter. Credit-based `alu_is_ready` back-pressures the reservation station.

## Interface
- RESULT_DEPTH, 3, result-buffer entries; also the in-flight credit limit (E register + buffer); must be ≥2
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- flush  in  1  mispredict flush; drops all in-flight and buffered ops
- iss  in  rs_to_alu_t  issued uop: valid, pd, rob_id, ps1, ps2, alu_op, op1_sel, op2_sel, imm[31:0], pc[31:0]
- alu_is_ready  out  1  unit can accept an issue this cycle
- prf_rs1_addr  out  PREG_W  = iss.ps1, combinational
- prf_rs2_addr  out  PREG_W  = iss.ps2, combinational
- prf_rs1_data  in  32  combinational PRF read data for prf_rs1_addr
- prf_rs2_data  in  32  combinational PRF read data for prf_rs2_addr
- cdb_req  out  1  buffer head valid, requesting broadcast
- cdb_out  out  cdb_entry_t  head result: valid, pd, rob_id, data[31:0]
- cdb_grant  in  1  arbiter accepts cdb_out this cycle

## Operation
- Stage E (register): on iss.valid & alu_is_ready & ~flush, capture uop fields plus prf_rs1_data/prf_rs2_data; e_valid<=1, otherwise e_valid<=0.
- Compute (combinational from E): op1 = RS1 / PC / ZERO per op1_sel; op2 = RS2 / IMM per op2_sel.
- alu_op: ADD, SUB (mod 2^32), SLL, SRL, SRA (shamt = op2[4:0]), SLT (signed), SLTU, XOR, OR, AND. SLT/SLTU results are zero-extended 0/1.
- LUI = ZERO+IMM ADD; AUIPC = PC+IMM ADD.
- When e_valid is set, {pd, rob_id, result} is pushed into the result buffer at the end of the cycle.
- Buffer: in-order FIFO of RESULT_DEPTH entries with wrap-around pointers and a count. cdb_req = ~empty & ~flush; cdb_out = head with valid = cdb_req. Pop on cdb_req & cdb_grant.
- Credit: alu_is_ready = (e_valid + count) < RESULT_DEPTH. It does not depend on cdb_grant (no comb path arbiter→RS).
- Push and pop in the same cycle: count unchanged, both pointers advance.
- pd==0 results are still broadcast, because the ROB needs completion.
- Flush: e_valid<=0, count/pointers<=0; a same-cycle issue is dropped; cdb_grant is ignored.
- iss.valid while ~alu_is_ready is illegal (assert). A push to a full buffer is impossible by the credit rule (assert).

## Timing
- Issue accepted at edge of cycle N → E valid in N+1 → buffer entry at edge of N+1 → cdb_req earliest in N+2. Minimum issue→CDB latency is 2 cycles.
- With grant every cycle and RESULT_DEPTH=3: sustained 1 op/cycle, steady state e_valid=1, count=1.
- cdb_out holds stable while cdb_req & ~cdb_grant.
- Reset: e_valid=0, count=0, pointers=0. After the reset edge: alu_is_ready=1, cdb_req=0, cdb_out all zero.
- Reset mid-operation discards everything like flush. Flush and reset take effect at the same edge with identical results.

## Structure
- rv32i_types additions: alu_op_t enum, op1_sel_t {RS1,PC,ZERO}, op2_sel_t {RS2,IMM}, rs_to_alu_t fields above, cdb_entry_t, PREG_W, ROB_IDX_W.
- Sub-module alu_result_fifo (parameter DEPTH, payload cdb_entry_t, push/pop/flush/count). Compute logic stays inline.

## Test plan
- Issue ADD with rs1=5, rs2=7, pd=12, rob_id=3; grant tied high → cdb_req exactly 2 cycles later with data=12, pd=12, rob_id=3; single-cycle pulse.
- SRA rs1=0x8000_0000, op2=IMM 0x24 (shamt 4) → 0xF800_0000. SLTU 1 vs 0xFFFF_FFFF → 1. SLT same operands → 0. AUIPC pc=0x1000, imm=0x2000 → 0x3000.
- Grant held low, issue every cycle while ready → exactly 3 accepted, alu_is_ready low after the third reaches E. Release grant → results in issue order, ready returns.
- Back-to-back issues with continuous grant → 1 result/cycle, alu_is_ready never drops.
- Two buffered results plus E valid, assert flush with a same-cycle issue and grant → next cycle cdb_req=0, alu_is_ready=1, no result ever emerges.
- Assert rst mid-stream with cdb_req high → after the edge cdb_req=0, cdb_out=0, alu_is_ready=1.
